// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one single-port memory between the CPU fetch port and its
//            load/store port. Maps the text and data virtual windows onto
//            physical addresses, flags misaligned or unmapped accesses, and
//            stretches every transaction by WAIT_CYCLES access cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] TEXT_BASE   = 32'h0040_0000,
   parameter logic [31:0] DATA_BASE   = 32'h1001_0000,
   parameter int          TEXT_BYTES  = 8192,
   parameter int          DATA_BYTES  = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_size,
   input  logic        d_signed,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        d_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [13:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_size,
   output logic        mem_signed,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic        GNT_I     = 1'b0;
   localparam logic        GNT_D     = 1'b1;
   localparam logic [3:0]  CNT_INIT  = 4'(WAIT_CYCLES - 1);
   localparam logic [31:0] TEXT_SZ   = 32'(TEXT_BYTES);
   localparam logic [31:0] DATA_SZ   = 32'(DATA_BYTES);
   localparam logic [13:0] DATA_PHYS = 14'(TEXT_BYTES);

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_grant_q, last_grant_d;
   logic [13:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;

   logic        sel_d;
   logic [31:0] sel_addr;
   logic [1:0]  sel_size;
   logic [31:0] text_off;
   logic [31:0] data_off;
   logic        in_text;
   logic        in_data;
   logic        misaligned;
   logic [13:0] sel_phys;
   logic        sel_err;

   // Pick the requester (round-robin on a tie) and decode its address.
   // Unsigned wrap-around of the offsets makes a single compare per window.
   always_comb begin
      sel_d    = d_req && (!i_req || (last_grant_q == GNT_I));
      sel_addr = sel_d ? d_addr : i_addr;
      sel_size = sel_d ? d_size : 2'b00;
      text_off = sel_addr - TEXT_BASE;
      data_off = sel_addr - DATA_BASE;
      in_text  = (text_off < TEXT_SZ);
      in_data  = (data_off < DATA_SZ);
      sel_phys = 14'd0;
      if (in_text) begin
         sel_phys = text_off[13:0];
      end else if (in_data) begin
         sel_phys = data_off[13:0] + DATA_PHYS;
      end
      case (sel_size)
         2'b00:   misaligned = (sel_addr[1:0] != 2'b00);
         2'b01:   misaligned = sel_addr[0];
         2'b10:   misaligned = 1'b0;
         default: misaligned = 1'b1;
      endcase
      sel_err = misaligned || !(in_text || in_data);
   end

   // Next-state logic: grant in IDLE, count access cycles, ack in DONE.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      size_d       = size_q;
      signed_d     = signed_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (i_req || d_req) begin
               grant_d  = sel_d ? GNT_D : GNT_I;
               addr_d   = sel_phys;
               size_d   = sel_size;
               signed_d = sel_d ? d_signed : 1'b0;
               we_d     = sel_d ? d_we : 1'b0;
               wdata_d  = sel_d ? d_wdata : 32'd0;
               err_d    = sel_err;
               cnt_d    = CNT_INIT;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
               if (!we_q) begin
                  if (grant_q == GNT_D) begin
                     d_rdata_d = mem_rdata;
                  end else begin
                     i_rdata_d = mem_rdata;
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and transaction registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= GNT_I;
         last_grant_q <= GNT_D;
         addr_q       <= 14'd0;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         we_q         <= 1'b0;
         wdata_q      <= 32'd0;
         err_q        <= 1'b0;
         cnt_q        <= 4'd0;
         i_rdata_q    <= 32'd0;
         d_rdata_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   // Memory side is only driven during ACCESS; error transactions never enable it.
   assign mem_en     = (state_q == ST_ACCESS) && !err_q;
   assign mem_we     = mem_en && we_q && (cnt_q == 4'd0);
   assign mem_addr   = (state_q == ST_ACCESS) ? addr_q   : 14'd0;
   assign mem_wdata  = (state_q == ST_ACCESS) ? wdata_q  : 32'd0;
   assign mem_size   = (state_q == ST_ACCESS) ? size_q   : 2'b00;
   assign mem_signed = (state_q == ST_ACCESS) ? signed_q : 1'b0;

   assign i_ack   = (state_q == ST_DONE) && (grant_q == GNT_I);
   assign d_ack   = (state_q == ST_DONE) && (grant_q == GNT_D);
   assign i_err   = i_ack && err_q;
   assign d_err   = d_ack && err_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed bench for mem_bus_arbiter with a transaction-level model.
//            Instance 0 runs with one wait cycle, instance 1 with three.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

   localparam logic [31:0] TB_TEXT = 32'h0040_0000;
   localparam logic [31:0] TB_DATA = 32'h1001_0000;

   logic        clk = 1'b0;
   logic        rst0, rst1;
   logic        i_req [2];
   logic [31:0] i_addr [2];
   logic [31:0] i_rdata [2];
   logic        i_ack [2];
   logic        i_err [2];
   logic        d_req [2];
   logic        d_we [2];
   logic [31:0] d_addr [2];
   logic [31:0] d_wdata [2];
   logic [1:0]  d_size [2];
   logic        d_signed [2];
   logic [31:0] d_rdata [2];
   logic        d_ack [2];
   logic        d_err [2];
   logic        mem_en [2];
   logic        mem_we [2];
   logic [13:0] mem_addr [2];
   logic [31:0] mem_wdata [2];
   logic [1:0]  mem_size [2];
   logic        mem_signed [2];
   logic [31:0] mem_rdata [2];

   always #5 clk = ~clk;

   mem_bus_arbiter #(.WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst(rst0),
      .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ack(i_ack[0]), .i_err(i_err[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_size(d_size[0]),
      .d_signed(d_signed[0]), .d_rdata(d_rdata[0]), .d_ack(d_ack[0]), .d_err(d_err[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_size(mem_size[0]), .mem_signed(mem_signed[0]), .mem_rdata(mem_rdata[0])
   );

   mem_bus_arbiter #(.WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst1),
      .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ack(i_ack[1]), .i_err(i_err[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_size(d_size[1]),
      .d_signed(d_signed[1]), .d_rdata(d_rdata[1]), .d_ack(d_ack[1]), .d_err(d_err[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_size(mem_size[1]), .mem_signed(mem_signed[1]), .mem_rdata(mem_rdata[1])
   );

   // ---------------- physical memory seen by the DUTs ----------------
   function automatic logic [31:0] init_word(input logic [11:0] idx);
      return (idx == 12'd2) ? 32'h2402_0005 : (32'hA500_0000 ^ {20'd0, idx});
   endfunction

   bit [31:0] pd [2][4096];
   bit        pw [2][4096];
   assign mem_rdata[0] = pw[0][mem_addr[0][13:2]] ? pd[0][mem_addr[0][13:2]] : init_word(mem_addr[0][13:2]);
   assign mem_rdata[1] = pw[1][mem_addr[1][13:2]] ? pd[1][mem_addr[1][13:2]] : init_word(mem_addr[1][13:2]);

   initial begin
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            if (mem_we[k]) begin
               pd[k][mem_addr[k][13:2]] = mem_wdata[k];
               pw[k][mem_addr[k][13:2]] = 1'b1;
            end
         end
      end
   end

   // ---------------- checking bookkeeping ----------------
   int n_vec = 0;
   int n_err = 0;
   int we_cnt [2];
   int en_cnt [2];
   int ack_cnt [2];

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   int          m_ph [2];        // 0 idle, 1..W access cycle number, W+1 ack cycle
   bit          m_port [2];      // 1 = data port owns the transaction
   bit          m_last_d [2];
   bit          m_we [2];
   bit          m_err [2];
   bit          m_sgn [2];
   logic [13:0] m_phys [2];
   logic [1:0]  m_size [2];
   logic [31:0] m_wd [2];
   logic [31:0] exp_i [2];
   logic [31:0] exp_d [2];
   bit          i_known [2];
   bit          d_known [2];
   bit [31:0]   md [2][4096];
   bit          mw [2][4096];

   function automatic int wait_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] mread(input int k, input logic [11:0] idx);
      return mw[k][idx] ? md[k][idx] : init_word(idx);
   endfunction

   task automatic decode(input logic [31:0] a, input logic [1:0] sz,
                         output logic [13:0] ph, output bit er);
      longint ua;
      bit     mapped;
      ua     = {32'd0, a};
      mapped = 1'b1;
      ph     = 14'd0;
      if (ua >= longint'(TB_TEXT) && ua < longint'(TB_TEXT) + 8192)
         ph = 14'(ua - longint'(TB_TEXT));
      else if (ua >= longint'(TB_DATA) && ua < longint'(TB_DATA) + 128)
         ph = 14'(ua - longint'(TB_DATA) + 8192);
      else
         mapped = 1'b0;
      er = !mapped || (sz == 2'b11) || (sz == 2'b00 && (ua % 4) != 0) || (sz == 2'b01 && (ua % 2) != 0);
   endtask

   task automatic model_reset(input int k);
      m_ph[k] = 0; m_last_d[k] = 1'b1; m_port[k] = 1'b0; m_err[k] = 1'b0; m_we[k] = 1'b0;
      exp_i[k] = 32'd0; exp_d[k] = 32'd0; i_known[k] = 1'b1; d_known[k] = 1'b1;
   endtask

   task automatic model_step(input int k);
      int w;
      w = wait_of(k);
      if (m_ph[k] == 0) begin
         if (i_req[k] || d_req[k]) begin
            m_port[k] = d_req[k] && (!i_req[k] || !m_last_d[k]);
            if (m_port[k]) begin
               m_we[k] = d_we[k]; m_size[k] = d_size[k]; m_sgn[k] = d_signed[k]; m_wd[k] = d_wdata[k];
               decode(d_addr[k], d_size[k], m_phys[k], m_err[k]);
            end else begin
               m_we[k] = 1'b0; m_size[k] = 2'b00; m_sgn[k] = 1'b0; m_wd[k] = 32'd0;
               decode(i_addr[k], 2'b00, m_phys[k], m_err[k]);
            end
            m_ph[k] = 1;
         end
      end else if (m_ph[k] <= w) begin
         if (m_ph[k] == w) begin
            if (m_we[k] && !m_err[k]) begin
               md[k][m_phys[k][13:2]] = m_wd[k];
               mw[k][m_phys[k][13:2]] = 1'b1;
            end else if (!m_we[k]) begin
               if (m_port[k]) begin
                  exp_d[k] = mread(k, m_phys[k][13:2]); d_known[k] = !m_err[k];
               end else begin
                  exp_i[k] = mread(k, m_phys[k][13:2]); i_known[k] = !m_err[k];
               end
            end
         end
         m_ph[k] = m_ph[k] + 1;
      end else begin
         m_last_d[k] = m_port[k];
         m_ph[k]     = 0;
      end
   endtask

   initial begin
      model_reset(0);
      model_reset(1);
      forever begin
         @(posedge clk);
         if (!rst0) model_reset(0); else model_step(0);
         if (!rst1) model_reset(1); else model_step(1);
      end
   end

   task automatic compare_inst(input int k, input logic rk);
      int w;
      bit acc, ack_i, ack_d, exp_we;
      w = wait_of(k);
      if (!rk) begin
         chk("rst_mem_en", k, mem_en[k], 0);
         chk("rst_mem_we", k, mem_we[k], 0);
         chk("rst_mem_addr", k, mem_addr[k], 0);
         chk("rst_mem_wdata", k, mem_wdata[k], 0);
         chk("rst_mem_size", k, mem_size[k], 0);
         chk("rst_mem_signed", k, mem_signed[k], 0);
         chk("rst_i_ack", k, i_ack[k], 0);
         chk("rst_d_ack", k, d_ack[k], 0);
         chk("rst_i_err", k, i_err[k], 0);
         chk("rst_d_err", k, d_err[k], 0);
         chk("rst_i_rdata", k, i_rdata[k], 0);
         chk("rst_d_rdata", k, d_rdata[k], 0);
      end else begin
         acc    = (m_ph[k] >= 1) && (m_ph[k] <= w);
         exp_we = acc && (m_ph[k] == w) && m_we[k] && !m_err[k];
         ack_i  = (m_ph[k] == w + 1) && !m_port[k];
         ack_d  = (m_ph[k] == w + 1) && m_port[k];
         chk("mem_en", k, mem_en[k], acc && !m_err[k]);
         chk("mem_we", k, mem_we[k], exp_we);
         if (acc && !m_err[k]) begin
            chk("mem_addr", k, mem_addr[k], m_phys[k]);
            chk("mem_size", k, mem_size[k], m_size[k]);
            chk("mem_signed", k, mem_signed[k], m_sgn[k]);
         end
         if (exp_we) chk("mem_wdata", k, mem_wdata[k], m_wd[k]);
         chk("i_ack", k, i_ack[k], ack_i);
         chk("d_ack", k, d_ack[k], ack_d);
         chk("i_err", k, i_err[k], ack_i && m_err[k]);
         chk("d_err", k, d_err[k], ack_d && m_err[k]);
         if (i_known[k]) chk("i_rdata", k, i_rdata[k], exp_i[k]);
         if (d_known[k]) chk("d_rdata", k, d_rdata[k], exp_d[k]);
      end
   endtask

   initial begin
      we_cnt = '{0, 0}; en_cnt = '{0, 0}; ack_cnt = '{0, 0};
      forever begin
         @(negedge clk);
         compare_inst(0, rst0);
         compare_inst(1, rst1);
         for (int k = 0; k < 2; k++) begin
            if (mem_we[k]) we_cnt[k]++;
            if (mem_en[k]) en_cnt[k]++;
            if (i_ack[k] || d_ack[k]) ack_cnt[k]++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic txn(input int k, input bit port, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] sz, input bit sg,
                      output int lat, output logic er, output logic [31:0] rd, output logic [13:0] ma);
      bit got;
      got = 1'b0; lat = 0; er = 1'b0; rd = 32'd0; ma = 14'd0;
      @(negedge clk); #1;
      if (port) begin
         d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd; d_size[k] = sz; d_signed[k] = sg;
      end else begin
         i_req[k] = 1'b1; i_addr[k] = a;
      end
      for (int n = 1; n <= 40 && !got; n++) begin
         @(negedge clk);
         if (n == 1) ma = mem_addr[k];
         if (port ? d_ack[k] : i_ack[k]) begin
            got = 1'b1; lat = n;
            er  = port ? d_err[k] : i_err[k];
            rd  = port ? d_rdata[k] : i_rdata[k];
         end else begin
            // scramble the request after grant; the transaction must not notice
            #1;
            if (port) begin
               d_addr[k] = ~a; d_wdata[k] = ~wd; d_size[k] = ~sz; d_we[k] = ~we; d_signed[k] = ~sg;
            end else begin
               i_addr[k] = ~a;
            end
         end
      end
      if (!got) chk("ack_timeout", k, 0, 1);
      #1;
      i_req[k] = 1'b0; d_req[k] = 1'b0;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [1:0]  sz;
      bit          we;
   } err_vec_t;

   initial begin
      int          lat, nack, last_n, w0, e0, a0;
      logic        er;
      logic [31:0] rd;
      logic [13:0] ma;
      logic [3:0]  order;
      err_vec_t    ev [3];

      for (int k = 0; k < 2; k++) begin
         i_req[k] = 1'b0; i_addr[k] = 32'd0; d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 32'd0;
         d_wdata[k] = 32'd0; d_size[k] = 2'b00; d_signed[k] = 1'b0;
      end
      rst0 = 1'b0; rst1 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_i_rdata", 0, i_rdata[0], 32'd0);
      chk("reset_mem_en", 0, mem_en[0], 0);
      #1; rst0 = 1'b1; rst1 = 1'b1;

      // both ports requesting from reset: fetch first, then strict alternation
      @(negedge clk); #1;
      i_req[0] = 1'b1; i_addr[0] = 32'h0040_0000;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h1001_0000; d_size[0] = 2'b00; d_signed[0] = 1'b0;
      order = 4'd0; nack = 0; last_n = 0;
      for (int n = 1; n <= 60 && nack < 4; n++) begin
         @(negedge clk);
         if (i_ack[0]) begin
            nack++; last_n = n;
         end else if (d_ack[0]) begin
            order[nack] = 1'b1; nack++; last_n = n;
         end
      end
      #1; i_req[0] = 1'b0; d_req[0] = 1'b0;
      chk("rr_ack_count", 0, nack, 4);
      chk("rr_order", 0, order, 4'b1010);
      chk("rr_last_ack_cycle", 0, last_n, 11);

      // plain fetch
      txn(0, 0, 0, 32'h0040_0008, 32'd0, 2'b00, 0, lat, er, rd, ma);
      chk("fetch_latency", 0, lat, 2);
      chk("fetch_mem_addr", 0, ma, 14'h0008);
      chk("fetch_rdata", 0, rd, 32'h2402_0005);
      chk("fetch_err", 0, er, 0);

      // store word, then read it back
      w0 = we_cnt[0];
      txn(0, 1, 1, 32'h1001_0004, 32'hDEAD_BEEF, 2'b00, 0, lat, er, rd, ma);
      chk("store_mem_addr", 0, ma, 14'h2004);
      chk("store_we_pulses", 0, we_cnt[0] - w0, 1);
      chk("store_err", 0, er, 0);
      chk("store_latency", 0, lat, 2);
      txn(0, 1, 0, 32'h1001_0004, 32'd0, 2'b00, 0, lat, er, rd, ma);
      chk("load_rdata", 0, rd, 32'hDEAD_BEEF);
      chk("fetch_rdata_held", 0, i_rdata[0], 32'h2402_0005);

      // error transactions keep normal latency and never touch memory
      ev[0] = '{32'h1001_0001, 2'b01, 1'b0};
      ev[1] = '{32'h1001_0080, 2'b00, 1'b1};
      ev[2] = '{32'h1001_0000, 2'b11, 1'b1};
      for (int e = 0; e < 3; e++) begin
         w0 = we_cnt[0]; e0 = en_cnt[0];
         txn(0, 1, ev[e].we, ev[e].a, 32'h5555_AAAA, ev[e].sz, 0, lat, er, rd, ma);
         chk("err_flag", 0, er, 1);
         chk("err_latency", 0, lat, 2);
         chk("err_mem_en", 0, en_cnt[0] - e0, 0);
         chk("err_mem_we", 0, we_cnt[0] - w0, 0);
      end

      // window edges
      txn(0, 0, 0, 32'h0040_1FFC, 32'd0, 2'b00, 0, lat, er, rd, ma);
      chk("text_top_err", 0, er, 0);
      chk("text_top_addr", 0, ma, 14'h1FFC);
      txn(0, 0, 0, 32'h0040_2000, 32'd0, 2'b00, 0, lat, er, rd, ma);
      chk("text_past_err", 0, er, 1);
      txn(0, 0, 0, 32'h003F_FFFC, 32'd0, 2'b00, 0, lat, er, rd, ma);
      chk("text_below_err", 0, er, 1);
      txn(0, 0, 0, 32'h0040_0002, 32'd0, 2'b00, 0, lat, er, rd, ma);
      chk("fetch_misalign_err", 0, er, 1);
      txn(0, 1, 0, 32'h1001_007C, 32'd0, 2'b00, 0, lat, er, rd, ma);
      chk("data_top_err", 0, er, 0);
      chk("data_top_addr", 0, ma, 14'h207C);

      // sub-word accesses
      txn(0, 1, 0, 32'h1001_0003, 32'd0, 2'b10, 1, lat, er, rd, ma);
      chk("byte_load_err", 0, er, 0);
      chk("byte_load_addr", 0, ma, 14'h2003);
      w0 = we_cnt[0];
      txn(0, 1, 1, 32'h1001_0006, 32'h0000_BEEF, 2'b01, 0, lat, er, rd, ma);
      chk("half_store_err", 0, er, 0);
      chk("half_store_addr", 0, ma, 14'h2006);
      chk("half_store_we", 0, we_cnt[0] - w0, 1);

      // three wait cycles: reset in the middle of a store
      @(negedge clk); #1;
      d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h1001_0000; d_wdata[1] = 32'h1234_5678;
      d_size[1] = 2'b00; d_signed[1] = 1'b0;
      @(negedge clk);
      chk("w3_access_en", 1, mem_en[1], 1);
      chk("w3_access_addr", 1, mem_addr[1], 14'h2000);
      @(negedge clk); #1;
      rst1 = 1'b0; #1;
      chk("abort_mem_en", 1, mem_en[1], 0);
      chk("abort_mem_addr", 1, mem_addr[1], 0);
      chk("abort_mem_wdata", 1, mem_wdata[1], 0);
      chk("abort_mem_we", 1, mem_we[1], 0);
      chk("abort_d_ack", 1, d_ack[1], 0);
      w0 = we_cnt[1]; a0 = ack_cnt[1];
      repeat (3) @(negedge clk);
      #1; d_req[1] = 1'b0; d_we[1] = 1'b0; rst1 = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_write", 1, we_cnt[1] - w0, 0);
      chk("abort_no_ack", 1, ack_cnt[1] - a0, 0);
      txn(1, 1, 0, 32'h1001_0000, 32'd0, 2'b00, 0, lat, er, rd, ma);
      chk("w3_latency", 1, lat, 4);
      chk("w3_rdata_unwritten", 1, rd, 32'hA500_0800);
      chk("w3_err", 1, er, 0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port unified memory between the multi-cycle CPU's instruction-fetch port and its load/store port.
- Performs virtual-to-physical window mapping for the text (0x0040_0000) and data (0x1001_0000) segments.
- Checks alignment and range, and inserts a configurable number of memory wait states.
- Sits between the cpu instance and the memory in the top-level dataflow wrapper.
- Returns a one-cycle ack per transaction to the requesting port.

Parameters:
- WAIT_CYCLES, 1: memory access cycles per transaction (legal range 1..15).
- TEXT_BASE, 32'h0040_0000: virtual base of the instruction window.
- DATA_BASE, 32'h1001_0000: virtual base of the data window.
- TEXT_BYTES, 8192: instruction window size. Maps to physical 0..TEXT_BYTES-1.
- DATA_BYTES, 128: data window size. Maps to physical TEXT_BYTES..TEXT_BYTES+DATA_BYTES-1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  32  fetch virtual address.
- i_rdata  out  32  fetched word; valid in the i_ack cycle and held until the next i_ack.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  valid with i_ack; set on misaligned or out-of-window address.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data virtual address.
- d_wdata  in  32  store data, right-aligned.
- d_size  in  2  00 word, 01 half, 10 byte; 11 is illegal and gives d_err.
- d_signed  in  1  sign-extend sub-word loads.
- d_rdata  out  32  load result; valid in the d_ack cycle and held until the next d_ack.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  valid with d_ack.
- mem_en  out  1  memory access active.
- mem_we  out  1  write strobe.
- mem_addr  out  14  physical byte address.
- mem_wdata  out  32  write data.
- mem_size  out  2  access size, copied from the granted request.
- mem_signed  out  1  load sign-extension flag.
- mem_rdata  in  32  combinational read data for mem_addr.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All outputs go to 0, including held rdata registers, err flags, wait counter and grant.
  - last_grant goes to DATA, so the first tie goes to fetch.
  - A transaction in flight is aborted with no ack and no write.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port that is not last_grant (round-robin).
  - On grant: register the port, address, size, signed flag, write flag and wdata.
  - On grant: compute physical address and error; counter = WAIT_CYCLES-1; go to ACCESS.
- Physical mapping:
  - addr in [TEXT_BASE, TEXT_BASE+TEXT_BYTES) -> addr-TEXT_BASE.
  - addr in [DATA_BASE, DATA_BASE+DATA_BYTES) -> addr-DATA_BASE+TEXT_BYTES.
  - Any other address is an error.
  - Fetch is always a word access, unsigned, never a write.
- Errors: misaligned word (addr[1:0]!=0), misaligned half (addr[0]!=0), d_size=11, or out of window.
- ACCESS:
  - mem_en=1 and mem_addr, mem_size, mem_signed are driven from the registered values, every cycle in ACCESS.
  - On an error transaction, mem_en and mem_we stay 0 for the whole transaction; latency is unchanged.
  - Counter decrements each cycle.
  - On the cycle the counter is 0: pulse mem_we if the transaction is a store; capture mem_rdata into the granted port's rdata register (loads and fetches only); go to DONE.
  - Exactly one write strobe is issued per store.
- DONE:
  - Assert the granted port's ack for one cycle, with err.
  - Update last_grant.
  - Return to IDLE. The next grant can happen in the following cycle, not in DONE itself.
- Latency: request seen in IDLE at cycle 0 -> ACCESS in cycles 1..WAIT_CYCLES -> ack at cycle WAIT_CYCLES+1.
- Throughput: one transaction per WAIT_CYCLES+2 cycles.
- A request that drops mid-transaction does not cancel it; the ack is still issued.
- Changes to the inputs after grant are ignored.
- The ungranted port's rdata, ack and err are unaffected by the other port's transaction.

Test Plan:
- WAIT_CYCLES=1, fetch only, i_addr=0x0040_0008, mem_rdata=0x2402_0005 -> mem_addr=0x0008 in cycle 1; i_ack at cycle 2; i_rdata=0x2402_0005, held afterwards.
- Store word d_addr=0x1001_0004, d_wdata=0xDEAD_BEEF -> mem_addr=0x2004; exactly one mem_we pulse; d_ack with d_err=0.
- i_req and d_req both high from reset -> fetch granted first, data second; with both held, grants alternate I, D, I, D; no starvation.
- Error cases, each: half at 0x1001_0001, word at 0x1001_0080, d_size=11 -> d_ack at normal latency with d_err=1; mem_en and mem_we never high.
- WAIT_CYCLES=3: assert rst low during ACCESS of a store -> all outputs 0 immediately; no mem_we; no ack; after release, a new request completes normally at cycle 4.
